// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Slice counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top bit.
module adder_slice #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             cmsb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co   = c[DIGIT];
  assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial two's-complement adder/subtractor with valid/ready on both sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : gen_param_check
    $error("serial_adder: WIDTH must be a non-zero multiple of DIGIT, DIGIT >= 1");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0]       slice_s;
  logic                   slice_co;
  logic                   slice_cmsb;
  logic [WIDTH+DIGIT-1:0] acc_shift;

  adder_slice #(
    .DIGIT(DIGIT)
  ) u_slice (
    .x   (a_q[DIGIT-1:0]),
    .y   (b_q[DIGIT-1:0]),
    .ci  (carry_q),
    .s   (slice_s),
    .co  (slice_co),
    .cmsb(slice_cmsb)
  );

  // New slice enters at the top; after N shifts the LSB slice sits at bit 0.
  assign acc_shift = {slice_s, acc_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d   = acc_shift[WIDTH+DIGIT-1:DIGIT];
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = slice_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          sum_d   = acc_d;
          cout_d  = slice_co;
          ovf_d   = slice_cmsb ^ slice_co;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: default 32/4 instance plus an 8/8 instance.
module tb_serial_adder;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, cin, sub, cout, ovf;
  logic [31:0] a, b, sum;

  logic       n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_cin, n_sub, n_cout, n_ovf;
  logic [7:0] n_a, n_b, n_sum;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  serial_adder #(.WIDTH(32), .DIGIT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) dut_n (
    .clk      (clk),
    .rst      (rst),
    .in_valid (n_in_valid),
    .in_ready (n_in_ready),
    .a        (n_a),
    .b        (n_b),
    .cin      (n_cin),
    .sub      (n_sub),
    .out_valid(n_out_valid),
    .out_ready(n_out_ready),
    .sum      (n_sum),
    .cout     (n_cout),
    .ovf      (n_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent reference: wide integer add, overflow from operand/result signs.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic c,
                                 input logic s);
    logic [32:0] r;
    logic [31:0] yy;
    exp_t        e;
    yy  = s ? ~y : y;
    r   = {1'b0, x} + {1'b0, yy} + {32'd0, (s ? 1'b1 : c)};
    e.s = r[31:0];
    e.c = r[32];
    e.o = (x[31] == yy[31]) && (r[31] != x[31]);
    return e;
  endfunction

  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic xc,
                        input logic xs, input int hold, input exp_t e);
    int          lat;
    exp_t        got;
    logic [31:0] s0;
    logic        c0, o0;
    exp_q.push_back(e);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a        = xa;
    b        = xb;
    cin      = xc;
    sub      = xs;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = ~xa;
    b        = xa ^ xb;
    lat      = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 3) begin
        a   = $urandom;
        b   = $urandom;
        sub = ~xs;
        cin = ~xc;
      end
    end
    check("latency", 32'(lat), 32'd8);
    got = exp_q.size() > 0 ? exp_q.pop_front() : '0;
    check("sum", sum, got.s);
    check("cout", 32'(cout), 32'(got.c));
    check("ovf", 32'(ovf), 32'(got.o));
    s0 = sum;
    c0 = cout;
    o0 = ovf;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("bp_sum", sum, s0);
      check("bp_flags", {30'd0, cout, ovf}, {30'd0, c0, o0});
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_hs_in_ready", 32'(in_ready), 32'd1);
    check("post_hs_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rc, rs;
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    a           = '0;
    b           = '0;
    cin         = 1'b0;
    sub         = 1'b0;
    n_in_valid  = 1'b0;
    n_out_ready = 1'b0;
    n_a         = '0;
    n_b         = '0;
    n_cin       = 1'b0;
    n_sub       = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", sum, 32'd0);
    check("rst_flags", {30'd0, cout, ovf}, 32'd0);

    run_op(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 0, '{s: 32'h0000_0000, c: 1'b1, o: 1'b0});
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 0, '{s: 32'h8000_0000, c: 1'b0, o: 1'b1});
    run_op(32'd5, 32'd7, 1'b1, 1'b1, 5, '{s: 32'hFFFF_FFFE, c: 1'b0, o: 1'b0});
    for (int k = 0; k < 4; k++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rc, rs, k, model(ra, rb, rc, rs));
    end
    run_op(32'h8000_0000, 32'd1, 1'b0, 1'b1, 0, '{s: 32'h7FFF_FFFF, c: 1'b1, o: 1'b1});

    // Abort mid-RUN with asynchronous reset.
    @(negedge clk);
    a        = 32'h1234_5678;
    b        = 32'h0BAD_F00D;
    cin      = 1'b0;
    sub      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("run_holds_sum", sum, 32'h7FFF_FFFF);
    check("run_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    check("async_rst_sum", sum, 32'd0);
    check("async_rst_flags", {30'd0, cout, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(32'd3, 32'd4, 1'b0, 1'b0, 0, '{s: 32'd7, c: 1'b0, o: 1'b0});

    // Single-slice configuration.
    @(negedge clk);
    check("n_in_ready", 32'(n_in_ready), 32'd1);
    n_a        = 8'h80;
    n_b        = 8'h80;
    n_in_valid = 1'b1;
    @(posedge clk);
    #1;
    n_in_valid = 1'b0;
    check("n_run_out_valid", 32'(n_out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("n_out_valid", 32'(n_out_valid), 32'd1);
    check("n_sum", 32'(n_sum), 32'h00);
    check("n_cout", 32'(n_cout), 32'd1);
    check("n_ovf", 32'(n_ovf), 32'd1);
    n_out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_out_ready = 1'b0;
    check("n_post_hs_in_ready", 32'(n_in_ready), 32'd1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

- Multi-cycle, parametrised two's-complement adder/subtractor.
- Processes `DIGIT` bits per clock through a registered carry. This trades latency for area in the datapath.
- Operands enter and results leave through valid/ready handshakes, so the block drops into streaming arithmetic paths in place of a wide single-cycle ripple adder.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width. Must be ≥ 1.
- `DIGIT`, 4: bits processed per cycle. Must satisfy 1 ≤ `DIGIT` ≤ `WIDTH` and `WIDTH % DIGIT == 0`. Elaboration fails otherwise.

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: operands present.
- `in_ready`  out  1: block can accept operands.
- `a`  in  `WIDTH`: operand A.
- `b`  in  `WIDTH`: operand B.
- `cin`  in  1: carry-in (add mode only).
- `sub`  in  1: 0 = `a+b+cin`; 1 = `a-b` (`a+~b+1`, `cin` ignored).
- `out_valid`  out  1: result present.
- `out_ready`  in  1: consumer takes result.
- `sum`  out  `WIDTH`: result.
- `cout`  out  1: carry out of MSB. In subtract mode, 1 = no borrow.
- `ovf`  out  1: signed overflow, defined as carry into MSB XOR carry out of MSB.

## Operation
- `N = WIDTH/DIGIT` slices.
- States:
  - IDLE
  - RUN, with a slice counter running 0..N-1
  - DONE
- IDLE:
  - `in_ready=1`.
  - On `in_valid && in_ready`: latch `a` into a shift register and latch `b` (inverted if `sub`).
  - Set the carry register to `sub ? 1 : cin`, clear the counter, go to RUN.
- RUN, each cycle:
  - Add the low `DIGIT` bits of both shift registers plus the carry.
  - Shift the slice sum into the top of the result register (LSB slice first).
  - Shift the operands right by `DIGIT` and update the carry.
  - On the last slice, capture `cout` (final carry) and `ovf` (carry into MSB XOR final carry), then go to DONE.
- DONE:
  - `out_valid=1`. `sum`, `cout` and `ovf` hold stable.
  - On `out_valid && out_ready`, go to IDLE.
- `in_ready` is high only in IDLE; `out_valid` is high only in DONE. There is no overlap of operations.
- `a`, `b`, `cin` and `sub` are sampled only on the input handshake edge. Later changes have no effect.
- `sum`, `cout` and `ovf` keep the last result through IDLE and RUN, until the next DONE overwrites them.
- Reset, at any time including mid-RUN:
  - State goes to IDLE, which gives `in_ready=1` and `out_valid=0`.
  - `sum=0`, `cout=0`, `ovf=0`, counter and carry cleared.
  - Any in-flight operation is discarded.

## Timing
- Input accept edge E0. Slices are computed on edges E1..EN.
- `out_valid` rises after EN, i.e. N cycles after E0 (8 at defaults).
- Output handshake edge H: `in_ready` is high from the cycle after H. The earliest next accept is at H+1.
- Throughput: one operation per N+2 cycles when `out_ready` is held high.
- `DIGIT == WIDTH`: N=1, one RUN cycle, `out_valid` one cycle after accept.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `in_valid`/`out_ready`.

## Structure
- Package `serial_adder_pkg`: state enum typedef (IDLE/RUN/DONE).
- Sub-module `adder_slice`: combinational `DIGIT`-bit ripple adder.
  - Inputs: `x`, `y`, `ci`.
  - Outputs: `s`, `co`, and `cmsb` (carry into its top bit, used for `ovf`).
- `serial_adder` holds the FSM, counter (`$clog2(N)` bits, minimum 1), shift registers and carry register.

## Test plan
- Add, `a=0xFFFFFFFF`, `b=0`, `cin=1`, `sub=0` -> `sum=0x00000000`, `cout=1`, `ovf=0`; `out_valid` exactly 8 cycles after accept.
- Add, `a=0x7FFFFFFF`, `b=1`, `cin=0` -> `sum=0x80000000`, `cout=0`, `ovf=1`.
- Subtract:
  - `a=5`, `b=7`, `sub=1`, `cin=1` (ignored) -> `sum=0xFFFFFFFE`, `cout=0`, `ovf=0`.
  - `a=0x80000000`, `b=1` -> `sum=0x7FFFFFFF`, `cout=1`, `ovf=1`.
- Backpressure: hold `out_ready=0` for 5 cycles after `out_valid`.
  - `sum`/`cout`/`ovf` stay stable and `in_ready` stays 0.
  - Raise `out_ready`: handshake, then `in_ready=1` next cycle.
  - Changing `a`/`b` during RUN has no effect on the result.
- Reset and small configuration:
  - Assert `rst` asynchronously on the 3rd RUN cycle -> `out_valid=0`, `in_ready=1`, `sum=0` immediately. A fresh `3+4` completes normally with `sum=7`.
  - Repeat at `WIDTH=8`, `DIGIT=8`: `0x80+0x80` -> `sum=0x00`, `cout=1`, `ovf=1`, latency 1 cycle.
